dm_write_logger: RTL and testbench

Trace stage directly downstream of `processor_arm`'s data-memory write port. Snoops every data-memory store (`DM_writeEnable`, `DM_addr`, `DM_writeData`) into a circular trace buffer. On `dump`, drains the captured stores in order over a valid/ready stream to the bench or host. Replaces ad-hoc memory dumps with an ordered, sequence-numbered store log.

---
 rtl/dm_log_pkg.sv | 11 +
 rtl/dm_log_fifo.sv | 37 +++
 rtl/dm_write_logger.sv | 69 ++++++
 tb/tb_dm_write_logger.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_log_pkg.sv
// dm_log_pkg: shared FSM state and trace-entry types for dm_write_logger
package dm_log_pkg;
  localparam int DM_LOG_N = 64;
  localparam int DM_LOG_SEQ_W = 16;
  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} dm_log_state_t;
  typedef struct packed {
    logic [DM_LOG_N-1:0]     addr;
    logic [DM_LOG_N-1:0]     data;
    logic [DM_LOG_SEQ_W-1:0] seq;
  } dm_log_entry_t;
endpackage

// File: rtl/dm_log_fifo.sv
// dm_log_fifo: circular trace storage; a push into a full buffer overwrites the oldest entry
module dm_log_fifo import dm_log_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  dm_log_entry_t wdata,
  output dm_log_entry_t rdata,
  output logic [CW-1:0] count,
  output logic          full
);
  dm_log_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (do_pop || (push && full)) rp <= rp + 1'b1;
      if (push && !do_pop && !full) count <= count + 1'b1;
      else if (do_pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/dm_write_logger.sv
// dm_write_logger: snoops data-memory stores into a circular trace and drains them on dump.
// Define DM_LOG_FILTER_EN to log only stores with LO_ADDR <= DM_addr <= HI_ADDR.
module dm_write_logger import dm_log_pkg::*; #(
  parameter int N = DM_LOG_N,
  parameter int DEPTH = 16,
  parameter int SEQ_W = DM_LOG_SEQ_W,
  parameter logic [N-1:0] LO_ADDR = '0,
  parameter logic [N-1:0] HI_ADDR = '1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             DM_writeEnable,
  input  logic [N-1:0]     DM_addr,
  input  logic [N-1:0]     DM_writeData,
  input  logic             dump,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_addr,
  output logic [N-1:0]     out_data,
  output logic [SEQ_W-1:0] out_seq,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             busy
);
  dm_log_state_t state, state_n;
  logic [SEQ_W-1:0] seq;
  logic in_win, push, pop, lost, full;
  dm_log_entry_t wdata, rdata;
`ifdef DM_LOG_FILTER_EN
  assign in_win = DM_addr >= LO_ADDR && DM_addr <= HI_ADDR;
`else
  logic unused_win;
  assign unused_win = ^{LO_ADDR, HI_ADDR};
  assign in_win = 1'b1;
`endif
  assign push = state == CAPTURE && DM_writeEnable && in_win;
  assign lost = state == DRAIN && DM_writeEnable && in_win;
  assign out_valid = state == DRAIN && count != '0;
  assign pop = out_valid && out_ready;
  assign busy = state != CAPTURE;
  assign wdata = '{addr: DM_LOG_N'(DM_addr), data: DM_LOG_N'(DM_writeData), seq: DM_LOG_SEQ_W'(seq)};
  // Fields read as zero whenever no entry is being offered.
  assign out_addr = out_valid ? N'(rdata.addr) : '0;
  assign out_data = out_valid ? N'(rdata.data) : '0;
  assign out_seq = out_valid ? SEQ_W'(rdata.seq) : '0;
  dm_log_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(CLOCK_50), .rst(reset), .push(push), .pop(pop),
    .wdata(wdata), .rdata(rdata), .count(count), .full(full)
  );
  always_comb begin
    state_n = state;
    state_n = state == CAPTURE ? (dump ? DRAIN : CAPTURE) :
              state == DRAIN   ? (count == '0 ? DONE : DRAIN) :
                                 (dump ? DONE : CAPTURE);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= CAPTURE;
      seq <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (push) seq <= seq + 1'b1;
      if (state == DONE && !dump) overflow <= 1'b0;
      else if ((push && full) || lost) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dm_write_logger.sv
// tb_dm_write_logger: table vectors, directed corner sequences and random traffic vs a queue model
module tb_dm_write_logger;
  localparam int N = 64, DEPTH = 16, SEQ_W = 16, CW = $clog2(DEPTH) + 1;
  localparam logic [N-1:0] LO = 64'h100, HI = 64'h1FF;
`ifdef DM_LOG_FILTER_EN
  localparam logic [N-1:0] AB = 64'h100;
  localparam int FILT_CNT = 2;
  localparam logic [N-1:0] FILT_FIRST = 64'h100;
`else
  localparam logic [N-1:0] AB = 64'h0;
  localparam int FILT_CNT = 4;
  localparam logic [N-1:0] FILT_FIRST = 64'hF8;
`endif
  logic clk = 0, rst = 1, we = 0, dump = 0, rdy = 0;
  logic [N-1:0] addr = '0, data = '0;
  logic out_valid, overflow, busy;
  logic [N-1:0] out_addr, out_data;
  logic [SEQ_W-1:0] out_seq;
  logic [CW-1:0] count;
  int total = 0, bad = 0;
  typedef struct {logic [N-1:0] a; logic [N-1:0] d; logic [SEQ_W-1:0] s;} ent_t;
  ent_t q[$];
  int seq_m = 0, ph = 0;
  bit ovf_m = 0;
  typedef struct {
    logic w; logic [N-1:0] a; logic [N-1:0] d; logic du; logic r;
    int cnt; logic v; logic b; logic o; logic [N-1:0] ea; logic [N-1:0] ed; logic [SEQ_W-1:0] es;
  } vec_t;
  vec_t tv[9];

  always #5 clk = ~clk;

  dm_write_logger #(.N(N), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .LO_ADDR(LO), .HI_ADDR(HI)) dut (
    .CLOCK_50(clk), .reset(rst), .DM_writeEnable(we), .DM_addr(addr), .DM_writeData(data),
    .dump(dump), .out_valid(out_valid), .out_ready(rdy), .out_addr(out_addr),
    .out_data(out_data), .out_seq(out_seq), .count(count), .overflow(overflow), .busy(busy)
  );

  function automatic bit win(logic [N-1:0] a);
`ifdef DM_LOG_FILTER_EN
    return a >= LO && a <= HI;
`else
    return 1'b1 | (^a);
`endif
  endfunction

  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Store log behaviour: capture phase logs stores, drain phase hands them out, done waits for dump low.
  task automatic model_step();
    if (rst) begin
      q.delete(); seq_m = 0; ovf_m = 0; ph = 0;
    end else if (ph == 0) begin
      if (we && win(addr)) begin
        if (q.size() == DEPTH) begin q.delete(0); ovf_m = 1; end
        q.push_back('{addr, data, SEQ_W'(seq_m)});
        seq_m = (seq_m + 1) % (1 << SEQ_W);
      end
      if (dump) ph = 1;
    end else if (ph == 1) begin
      if (we && win(addr)) ovf_m = 1;
      if (q.size() == 0) ph = 2;
      else if (rdy) q.delete(0);
    end else if (!dump) begin
      ph = 0; ovf_m = 0;
    end
  endtask

  task automatic cmp();
    bit ev;
    ev = ph == 1 && q.size() != 0;
    chk("m_count", count, q.size());
    chk("m_overflow", overflow, ovf_m);
    chk("m_busy", busy, ph != 0);
    chk("m_valid", out_valid, ev);
    chk("m_addr", out_addr, ev ? q[0].a : '0);
    chk("m_data", out_data, ev ? q[0].d : '0);
    chk("m_seq", out_seq, ev ? q[0].s : '0);
  endtask

  task automatic cyc(logic w, logic [N-1:0] a, logic [N-1:0] d, logic du, logic r);
    we = w; addr = a; data = d; dump = du; rdy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp();
  endtask

  task automatic rst_cycle();
    rst = 1;
    cyc(0, '0, '0, 0, 0);
    rst = 0;
  endtask

  initial begin
    int beats, first, last;
    logic [N-1:0] ha, hd;
    logic [SEQ_W-1:0] hs;
    logic pat[7];
    logic du_r;
    tv[0] = '{1, AB,        64'hA, 0, 1, 1, 0, 0, 0, 64'h0,      64'h0, 0};
    tv[1] = '{1, AB + 'h8,  64'hB, 0, 1, 2, 0, 0, 0, 64'h0,      64'h0, 0};
    tv[2] = '{1, AB + 'h10, 64'hC, 0, 1, 3, 0, 0, 0, 64'h0,      64'h0, 0};
    tv[3] = '{0, 64'h0,     64'h0, 1, 1, 3, 1, 1, 0, AB,         64'hA, 0};
    tv[4] = '{0, 64'h0,     64'h0, 1, 1, 2, 1, 1, 0, AB + 'h8,   64'hB, 1};
    tv[5] = '{0, 64'h0,     64'h0, 1, 1, 1, 1, 1, 0, AB + 'h10,  64'hC, 2};
    tv[6] = '{0, 64'h0,     64'h0, 1, 1, 0, 0, 1, 0, 64'h0,      64'h0, 0};
    tv[7] = '{0, 64'h0,     64'h0, 1, 1, 0, 0, 1, 0, 64'h0,      64'h0, 0};
    tv[8] = '{0, 64'h0,     64'h0, 0, 1, 0, 0, 0, 0, 64'h0,      64'h0, 0};
    rst_cycle();
    rst_cycle();
    chk("reset_count", count, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].w, tv[i].a, tv[i].d, tv[i].du, tv[i].r);
      chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
      chk($sformatf("tv%0d_valid", i), out_valid, tv[i].v);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].b);
      chk($sformatf("tv%0d_ovf", i), overflow, tv[i].o);
      chk($sformatf("tv%0d_addr", i), out_addr, tv[i].ea);
      chk($sformatf("tv%0d_data", i), out_data, tv[i].ed);
      chk($sformatf("tv%0d_seq", i), out_seq, tv[i].es);
    end

    rst_cycle();
    for (int i = 0; i < 20; i++) cyc(1, AB + N'(i * 8), N'(i), 0, 0);
    chk("full_count", count, 16);
    chk("full_ovf", overflow, 1);
    beats = 0; first = -1; last = -1;
    cyc(0, '0, '0, 1, 1);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        if (beats == 0) first = int'(out_seq);
        last = int'(out_seq);
        beats++;
      end
      cyc(0, '0, '0, 1, 1);
    end
    chk("full_beats", N'(beats), 16);
    chk("full_first_seq", N'(first), 4);
    chk("full_last_seq", N'(last), 19);
    cyc(0, '0, '0, 0, 0);
    chk("done_clears_ovf", overflow, 0);

    rst_cycle();
    for (int i = 0; i < 3; i++) cyc(1, AB + N'(i * 8), N'(i + 1), 0, 0);
    cyc(0, '0, '0, 1, 0);
    pat = '{1, 0, 0, 1, 1, 1, 1};
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      ha = out_addr; hd = out_data; hs = out_seq;
      if (out_valid && pat[i]) beats++;
      cyc(0, '0, '0, 1, pat[i]);
      if (!pat[i]) begin
        chk("stall_addr", out_addr, ha);
        chk("stall_data", out_data, hd);
        chk("stall_seq", out_seq, hs);
      end
    end
    chk("stall_beats", N'(beats), 3);
    cyc(0, '0, '0, 0, 0);

    rst_cycle();
    cyc(1, AB, 64'h1, 0, 0);
    cyc(1, AB + 'h8, 64'h2, 1, 0);
    chk("dump_store_count", count, 2);
    chk("dump_store_busy", busy, 1);
    cyc(1, AB + 'h10, 64'h3, 1, 0);
    chk("drain_store_ovf", overflow, 1);
    chk("drain_store_count", count, 2);
    for (int k = 0; k < 5; k++) cyc(0, '0, '0, 1, 1);
    cyc(0, '0, '0, 0, 0);

    rst_cycle();
    for (int i = 0; i < 5; i++) cyc(1, AB + N'(i * 8), N'(i), 0, 0);
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 1);
    cyc(0, '0, '0, 1, 1);
    chk("mid_count", count, 3);
    rst = 1;
    cyc(0, '0, '0, 1, 1);
    rst = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    cyc(1, AB + 'h40, 64'h55, 0, 0);
    cyc(0, '0, '0, 1, 0);
    chk("mid_rst_valid2", out_valid, 1);
    chk("mid_rst_seq0", out_seq, 0);

    rst_cycle();
    cyc(1, 64'hF8, 64'h1, 0, 0);
    cyc(1, 64'h100, 64'h2, 0, 0);
    cyc(1, 64'h1FF, 64'h3, 0, 0);
    cyc(1, 64'h200, 64'h4, 0, 0);
    chk("filt_count", count, FILT_CNT);
    cyc(0, '0, '0, 1, 0);
    chk("filt_first_addr", out_addr, FILT_FIRST);
    chk("filt_first_seq", out_seq, 0);
    for (int k = 0; k < 6; k++) cyc(0, '0, '0, 1, 1);
    cyc(0, '0, '0, 0, 0);

    du_r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) du_r = ~du_r;
      rst = $urandom_range(0, 299) == 0;
      cyc($urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : N'($urandom_range(0, 'h2FF)),
          {$urandom, $urandom}, du_r, $urandom_range(0, 2) != 0);
    end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
